wb_stage: RTL

- Write-back stage of the pipeline, directly downstream of the memory stage.
- Latches the memory stage's outputs into the MEM/WB register and selects the write-back data.
- Owns the 8x16 general-purpose register file, with two write ports (low/Rdst1 and high/Rdst2) and two decode read ports with write-through bypass.
- Drives the WB-side forwarding values used by the memory stage's second forwarding unit and keeps a retired-instruction counter.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_stage_regfile_2w2r.sv | 44 ++++
 rtl/wb_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths and the MEM/WB latch layout for the write-back stage.
package wb_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int REG_CNT = 2 ** ADDR_W;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rdst1;
    logic [DATA_W-1:0] rdst1_val;
    logic [ADDR_W-1:0] rdst2;
    logic [DATA_W-1:0] rdst2_val;
    logic [DATA_W-1:0] data;
    logic              mem_to_reg;
    logic              reglow_write;
    logic              reghigh_write;
  } mem_wb_t;

endpackage

// File: rtl/wb_stage_regfile_2w2r.sv
// 8x16 register file: two write ports (low port wins on a shared index)
// and two combinational read ports that bypass same-cycle writes.
module regfile_2w2r
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we_lo,
  input  logic [ADDR_W-1:0] idx_lo,
  input  logic [DATA_W-1:0] data_lo,
  input  logic              we_hi,
  input  logic [ADDR_W-1:0] idx_hi,
  input  logic [DATA_W-1:0] data_hi,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs [REG_CNT];

  // High port is assigned first so the low port's write overrides it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else begin
      if (we_hi) regs[idx_hi] <= data_hi;
      if (we_lo) regs[idx_lo] <= data_lo;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (we_lo && rd_addr_a == idx_lo)      rd_data_a = data_lo;
    else if (we_hi && rd_addr_a == idx_hi) rd_data_a = data_hi;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (we_lo && rd_addr_b == idx_lo)      rd_data_b = data_lo;
    else if (we_hi && rd_addr_b == idx_hi) rd_data_b = data_hi;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB latch, write-back select, register file,
// forwarding outputs and retired-instruction counter.
module wb_stage
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] Rdst1_in,
  input  logic [DATA_W-1:0] Rdst1_val_in,
  input  logic [ADDR_W-1:0] Rdst2_in,
  input  logic [DATA_W-1:0] Rdst2_val_in,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              memToReg_in,
  input  logic              reglow_write_in,
  input  logic              reghigh_write_in,
  input  logic [ADDR_W-1:0] rd_addr_a_in,
  input  logic [ADDR_W-1:0] rd_addr_b_in,
  output logic [DATA_W-1:0] rd_data_a_out,
  output logic [DATA_W-1:0] rd_data_b_out,
  output logic [DATA_W-1:0] DATA_Rdst1_WB_out,
  output logic [DATA_W-1:0] Rdst2_WB_out,
  output logic [ADDR_W-1:0] Rdst1_WB_idx_out,
  output logic [ADDR_W-1:0] Rdst2_WB_idx_out,
  output logic              reglow_write_WB_out,
  output logic              reghigh_write_WB_out,
  output logic [CNT_W-1:0]  retired_cnt_out
);

  mem_wb_t           mem_wb;
  mem_wb_t           mem_wb_next;
  logic              committed;
  logic              retire;
  logic              we_lo;
  logic              we_hi;
  logic [DATA_W-1:0] wb1;
  logic [DATA_W-1:0] wb2;
  logic [CNT_W-1:0]  retired_cnt;

  always_comb begin
    mem_wb_next.valid         = valid_in;
    mem_wb_next.rdst1         = Rdst1_in;
    mem_wb_next.rdst1_val     = Rdst1_val_in;
    mem_wb_next.rdst2         = Rdst2_in;
    mem_wb_next.rdst2_val     = Rdst2_val_in;
    mem_wb_next.data          = Data_in;
    mem_wb_next.mem_to_reg    = memToReg_in;
    mem_wb_next.reglow_write  = reglow_write_in;
    mem_wb_next.reghigh_write = reghigh_write_in;
  end

  // A held instruction is marked committed after its first edge so it
  // neither writes nor counts again while the stall persists.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wb    <= '0;
      committed <= 1'b0;
    end else if (flush_in) begin
      mem_wb    <= '0;
      committed <= 1'b0;
    end else if (stall_in) begin
      committed <= mem_wb.valid;
    end else begin
      mem_wb    <= mem_wb_next;
      committed <= 1'b0;
    end
  end

  assign retire = mem_wb.valid & ~committed;
  assign we_lo  = retire & mem_wb.reglow_write;
  assign we_hi  = retire & mem_wb.reghigh_write;
  assign wb1    = mem_wb.mem_to_reg ? mem_wb.data : mem_wb.rdst1_val;
  assign wb2    = mem_wb.rdst2_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + 1'b1;
  end

  regfile_2w2r u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_lo     (we_lo),
    .idx_lo    (mem_wb.rdst1),
    .data_lo   (wb1),
    .we_hi     (we_hi),
    .idx_hi    (mem_wb.rdst2),
    .data_hi   (wb2),
    .rd_addr_a (rd_addr_a_in),
    .rd_addr_b (rd_addr_b_in),
    .rd_data_a (rd_data_a_out),
    .rd_data_b (rd_data_b_out)
  );

  assign DATA_Rdst1_WB_out    = wb1;
  assign Rdst2_WB_out         = wb2;
  assign Rdst1_WB_idx_out     = mem_wb.rdst1;
  assign Rdst2_WB_idx_out     = mem_wb.rdst2;
  assign reglow_write_WB_out  = we_lo;
  assign reghigh_write_WB_out = we_hi;
  assign retired_cnt_out      = retired_cnt;

endmodule
